// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one N_BITS word per request as start bit, data LSB first, stop period.
// Bit timing is driven by an external oversampling tick shared with the receiver.
module uart_transmitter #(
  parameter int unsigned N_BITS     = 8,
  parameter int unsigned N_TICKS    = 16,
  parameter int unsigned STOP_TICKS = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_tx_start,
  input  logic              i_s_tick,
  input  logic [N_BITS-1:0] i_din,
  output logic              o_tx,
  output logic              o_tx_done_tick,
  output logic              o_busy
);

  localparam int unsigned S_MAX = (N_TICKS > STOP_TICKS) ? N_TICKS : STOP_TICKS;
  localparam int unsigned S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int unsigned N_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(N_TICKS - 1);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(STOP_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(N_BITS - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_e;

  state_e              state_q, state_d;
  logic [S_W-1:0]      s_q, s_d;
  logic [N_W-1:0]      n_q, n_d;
  logic [N_BITS-1:0]   b_q, b_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_tx_start) begin
          b_d     = i_din;
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (i_s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (i_s_tick) begin
          if (s_q == S_STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is derived from the next state so o_tx changes on the same edge as the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_tx           = tx_q;
  assign o_tx_done_tick = done_q;
  assign o_busy         = busy_q;

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serialises one N_BITS word per request onto the UART TX line as 8N1-style frames: start bit (0), data LSB first, stop bit(s) (1).
- Bit timing comes from the shared baud-rate tick generator via i_s_tick, at N_TICKS ticks per bit.
- Sits between the ALU result path and the Basys3 TX pin, and is the transmit-side counterpart of the UART receiver.
- Uses the same oversampling rate as the receiver, so one tick generator serves both.

Parameters:
- N_BITS, 8: data bits per frame.
- N_TICKS, 16: i_s_tick pulses per start or data bit.
- STOP_TICKS, 16: i_s_tick pulses in the stop period. 16 gives 1 stop bit, 24 gives 1.5, 32 gives 2.

Ports:
- i_clock, input, 1: system clock. The block uses this single clock only.
- i_reset, input, 1: asynchronous, active-high reset.
- i_tx_start, input, 1: single-cycle request to send i_din. Sampled only in IDLE.
- i_s_tick, input, 1: baud oversampling tick, one i_clock cycle wide.
- i_din, input, N_BITS: word to transmit. Sampled on the accepting edge only.
- o_tx, output, 1: serial line. Idle level is 1.
- o_tx_done_tick, output, 1: one-cycle pulse at end of frame.
- o_busy, output, 1: high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, tick counter s=0, bit counter n=0, shift register b=0.
  - o_tx=1, o_tx_done_tick=0, o_busy=0.
  - Asserting reset mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
- Output timing:
  - o_tx is driven by a flip-flop, never directly by combinational logic.
  - It is updated on the same edge as the state register, from next-state values.
  - Line level per state: IDLE=1, START=0, DATA=b[0], STOP=1.
- Counter widths:
  - s holds the maximum of N_TICKS-1 and STOP_TICKS-1.
  - n holds N_BITS-1.
  - Both wrap only under explicit clear; no implicit overflow is allowed.
- State machine, one-hot, 4 states:
  - IDLE: if i_tx_start=1, then b<=i_din, s<=0, and go to START. o_tx goes low on this same edge, so latency from request to start-bit edge is 1 cycle.
  - START: on each i_s_tick, if s==N_TICKS-1 then s<=0, n<=0, go to DATA; otherwise s<=s+1.
  - DATA: on each i_s_tick, if s==N_TICKS-1 then s<=0 and b<=b>>1.
    - If n==N_BITS-1, go to STOP.
    - Otherwise n<=n+1.
    - Else s<=s+1.
    - o_tx follows the new b[0].
  - STOP: on each i_s_tick, if s==STOP_TICKS-1 then go to IDLE and pulse o_tx_done_tick=1 on that edge; otherwise s<=s+1.
  - Illegal or unreachable state code: go to IDLE with o_tx=1.
- Ticks and cycle counts:
  - Cycles without i_s_tick change nothing.
  - Each bit therefore lasts exactly N_TICKS ticks (STOP_TICKS for the stop period).
- Handshake:
  - i_tx_start while o_busy=1 is ignored: no queueing, no corruption of the current frame.
  - i_din changes after acceptance have no effect.
- o_tx_done_tick:
  - High for exactly one cycle, coincident with the first cycle back in IDLE.
  - Never asserted outside that cycle.
- Back-to-back frames:
  - i_tx_start asserted in the same cycle o_tx_done_tick is high is accepted.
  - The next start bit follows the stop period with zero extra idle time.
- Simultaneous reset and i_tx_start: reset wins.

Test Plan:
- Reset, then idle with no requests: o_tx=1, o_busy=0, o_tx_done_tick=0 for 1000 cycles.
- Single frame, i_s_tick every 10 clocks, i_din=8'hA5, 1-cycle i_tx_start:
  - o_tx goes low 1 cycle later.
  - Line sequence, 160 clocks per bit: 0, 1,0,1,0,0,1,0,1, 1.
  - o_tx_done_tick pulses once about 1600 clocks after the start edge.
  - A loopback receiver outputs 8'hA5.
- i_tx_start with i_din=8'h3C pulsed mid-frame of 8'hA5, then i_din changed: line still carries only 8'hA5, and exactly one done pulse.
- Back-to-back: start with 8'h00, then re-assert start with 8'hFF in the done cycle:
  - Second start bit begins immediately after the first stop period.
  - Both bytes are received correctly.
  - Two done pulses.
- Asynchronous reset pulse between clock edges during the 4th data bit: o_tx=1 and o_busy=0 immediately, no done pulse, and the next request transmits a full, correct frame.
- STOP_TICKS=32: stop period lasts 32 ticks (320 clocks at 1 tick per 10 clocks) before o_tx_done_tick; other bit widths are unchanged.
